tx_unit: RTL
============

// Module: tx_unit
// PURPOSE
//  Transmitting unit of MiniUart. Accepts one byte from the CPU bus and sends it serially on
//  TxD as 8N1 frames: start bit, 8 data bits LSB first, stop bit.
//  en_tx is a clock-enable strobe from the shared divisor at OVERSAMPLE x baud, the same
//  strobe the receiving unit uses. One holding buffer lets the CPU queue the next byte while
//  the current frame shifts out.
// PARAMETERS
//  OVERSAMPLE  8  en_tx strobes per bit period; >=2; counter width = clog2(OVERSAMPLE)
//  DATA_BITS   8  data bits per frame (d_in width)
// PORTS
//  clk        in   1          system clock, all logic posedge
//  rst_n      in   1          one clock; reset is asynchronous and active-low
//  en_tx      in   1          oversample strobe, 1-cycle pulse, OVERSAMPLE x baud
//  d_in       in   DATA_BITS  byte to send, sampled when load=1
//  load       in   1          CPU write strobe for the transmit data register
//  ts         out  1          transmit status: 1 = holding buffer empty (may load)
//  busy       out  1          1 = frame in progress on txd
//  txd        out  1          serial output, idle high, registered
// BEHAVIOUR
//  Reset (rst_n=0, async): txd=1, ts=1, busy=0, fsm=IDLE, buffer empty, counters 0.
//  Load: load=1 with buffer empty latches d_in and clears ts next cycle.
//   load=1 with buffer full is dropped, buffer unchanged. Exception: load in the same
//   cycle the buffer drains into the shifter is accepted, so ts stays 0.
//  FSM advances only on en_tx=1 cycles. States: IDLE, START, DATA, [PARITY], STOP.
//   IDLE : if buffer full: shifter<=buffer, buffer emptied (ts<=1), txd<=0, busy<=1,
//          cnt_sample<=OVERSAMPLE-1, cnt_bits<=DATA_BITS-1, go START.
//   START: on cnt_sample==0: txd<=shifter[0], shift right, go DATA; reload cnt_sample.
//   DATA : on cnt_sample==0: if cnt_bits==0 go STOP (or PARITY) with txd<=1 (or parity bit);
//          else txd<=shifter[0], shift, cnt_bits-1. Reload cnt_sample.
//   STOP : on cnt_sample==0: if buffer full, start the next frame directly as from IDLE
//          (back-to-back, no idle gap); else busy<=0, go IDLE.
//   Other en_tx cycles: cnt_sample-1 only.
//   Illegal state: go IDLE with txd<=1.
//  Each bit lasts exactly OVERSAMPLE en_tx strobes. Frame = (DATA_BITS+2)*OVERSAMPLE
//   strobes (+OVERSAMPLE when parity is compiled in). First txd fall is 1 clk after the
//   first en_tx that sees a full buffer in IDLE.
//  en_tx held low: all state frozen, txd holds. load still accepted.
//  Reset mid-frame: txd returns to 1 immediately; the partial frame and buffer are discarded.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state between DATA and STOP sends even parity
//   (XOR of the 8 data bits) for one bit period; frame is 8E1.
//  Not defined: no PARITY state, DATA goes straight to STOP; frame is 8N1.
//  The receiving unit must be built with the same setting.
// STRUCTURE
//  head_uart.v: FSM state codes (TX_IDLE..TX_STOP), default OVERSAMPLE. Shared with the
//   receiving unit, which uses HALF_BIT derived from it.
//  Flat module, no sub-module. The parity generator is a single XOR reduction inline.
// TESTING
//  1. Reset, OVERSAMPLE=8, en_tx every 4 clk, load 0xA5 -> txd frame 0,1,0,1,0,0,1,0,1,1;
//     each bit = 8 strobes; ts re-asserts at start bit; busy low after stop.
//  2. Load 0x3C, then load 0xC3 during the start bit -> two frames back-to-back, no idle
//     gap; a third load while the buffer is full is dropped (only 2 frames seen).
//  3. Load in the exact cycle the buffer drains at STOP -> byte accepted, ts stays 0,
//     byte sent as the next frame.
//  4. Assert rst_n=0 during data bit 4 -> txd=1, ts=1, busy=0 asynchronously;
//     no further edges until a new load.
//  5. Hold en_tx=0 for 100 clk mid-frame -> txd and counters frozen; resume completes the
//     frame with correct bit widths.
//  6. UART_TX_PARITY_EN defined, loads 0x07 and 0x03 -> parity bits 1 and 0; frame 11 bits.
//     Loopback into the receiving unit returns 0x07 and 0x03 and rs asserts twice.

Source files
------------

// File: rtl/tx_unit_pkg.sv
// tx_unit_pkg: FSM state codes and default frame geometry for the MiniUart
// transmitting unit. The receiving unit derives its half-bit point from the
// same DEFAULT_OVERSAMPLE, so both ends stay in step.
package tx_unit_pkg;

    localparam int unsigned DEFAULT_OVERSAMPLE = 8;
    localparam int unsigned DEFAULT_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/tx_unit.sv
// tx_unit: MiniUart transmitter. Serialises one byte per frame on txd
// (start bit, data LSB first, stop bit), one holding buffer in front of the
// shifter so the CPU can queue the next byte while a frame shifts out.
// Every bit lasts OVERSAMPLE en_tx strobes.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data and stop bits (8E1 instead of 8N1).
module tx_unit
    import tx_unit_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_tx,
    input  logic [DATA_BITS-1:0] d_in,
    input  logic                 load,
    output logic                 ts,
    output logic                 busy,
    output logic                 txd
);

    localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST   = BW'(DATA_BITS - 1);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_buf;
    logic                 r_buf_full;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_cnt_sample;
    logic [BW-1:0]        r_cnt_bits;
    logic                 r_txd;
    logic                 r_busy;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_bit_end;
    logic w_drain;
    logic w_load_ok;

    // A frame starts (buffer moves into the shifter) either from IDLE or at
    // the last strobe of STOP; a CPU write in that very cycle refills the
    // buffer instead of being dropped.
    always_comb begin
        w_bit_end = en_tx && (r_cnt_sample == '0);
        w_drain   = r_buf_full && en_tx &&
                    ((r_state == TX_IDLE) || ((r_state == TX_STOP) && (r_cnt_sample == '0)));
        w_load_ok = load && (!r_buf_full || w_drain);
    end

    // Holding buffer: filled by the CPU, emptied when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_load_ok) begin
            r_buf      <= d_in;
            r_buf_full <= 1'b1;
        end else if (w_drain) begin
            r_buf_full <= 1'b0;
        end
    end

    // Frame FSM with registered txd/busy; advances only on en_tx strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= TX_IDLE;
            r_shift      <= '0;
            r_cnt_sample <= '0;
            r_cnt_bits   <= '0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else if (w_drain) begin
            // shared frame start for IDLE and back-to-back from STOP
            r_state      <= TX_START;
            r_shift      <= r_buf;
            r_cnt_sample <= SAMPLE_LAST;
            r_cnt_bits   <= BITS_LAST;
            r_txd        <= 1'b0;
            r_busy       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity     <= ^r_buf;
`endif
        end else if (en_tx) begin
            case (r_state)
                TX_IDLE: begin
                    r_cnt_sample <= r_cnt_sample;
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_txd        <= r_shift[0];
                        r_shift      <= r_shift >> 1;
                        r_cnt_sample <= SAMPLE_LAST;
                        r_state      <= TX_DATA;
                    end else begin
                        r_cnt_sample <= r_cnt_sample - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_cnt_sample <= SAMPLE_LAST;
                        if (r_cnt_bits == '0) begin
`ifdef UART_TX_PARITY_EN
                            r_txd   <= r_parity;
                            r_state <= TX_PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= TX_STOP;
`endif
                        end else begin
                            r_txd      <= r_shift[0];
                            r_shift    <= r_shift >> 1;
                            r_cnt_bits <= r_cnt_bits - 1'b1;
                        end
                    end else begin
                        r_cnt_sample <= r_cnt_sample - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (w_bit_end) begin
                        r_txd        <= 1'b1;
                        r_cnt_sample <= SAMPLE_LAST;
                        r_state      <= TX_STOP;
                    end else begin
                        r_cnt_sample <= r_cnt_sample - 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_bit_end) begin
                        r_busy  <= 1'b0;
                        r_state <= TX_IDLE;
                    end else begin
                        r_cnt_sample <= r_cnt_sample - 1'b1;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign ts   = ~r_buf_full;
    assign busy = r_busy;
    assign txd  = r_txd;

endmodule
